scan_result_resolver: RTL and testbench

Downstream of the SequencerGroup array. After each OP_SCAN/OP_SCIN it collects every group's compare result, overTgt, stop and rowFull. It reduces them to one scan result: hit flag, matching group, insertion-point group, row-full and row-empty. It then drives per-group insertPoint and grpMask lines for the following shift (insert) operation. Results go to the sequencer controller over a valid/ready handshake.

---
 rtl/scan_result_resolver_pkg.sv | 27 ++
 rtl/scan_result_resolver_lowest_set_finder.sv | 23 ++
 rtl/scan_result_resolver.sv | 174 +++++++++++++++++
 tb/tb_scan_result_resolver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_result_resolver_pkg.sv
// rtl/scan_result_resolver_pkg.sv - shared definitions for the scan result resolver (samDefines)
package scan_result_resolver_pkg;

  // Bit positions inside one group's two-bit compare result
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  // Default row geometry; the result struct is sized from these
  localparam int SAM_GROUP_CNT      = 32;
  localparam int SAM_GROUP_ADR_BITS = 5;

  // Resolver FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_RESOLVE = 3'd2;
  localparam logic [2:0] ST_REPORT  = 3'd3;
  localparam logic [2:0] ST_HELD    = 3'd4;

  typedef struct packed {
    logic                          hit;
    logic [SAM_GROUP_ADR_BITS-1:0] hitGrp;
    logic [SAM_GROUP_ADR_BITS:0]   insGrp;
    logic                          rowFull;
    logic                          empty;
  } SCAN_RSLT;

endpackage

// File: rtl/scan_result_resolver_lowest_set_finder.sv
// rtl/scan_result_resolver_lowest_set_finder.sv - priority finder for the lowest set bit of a vector
module lowest_set_finder #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 5
) (
  input  logic [WIDTH-1:0]    vec,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/scan_result_resolver.sv
// rtl/scan_result_resolver.sv - reduces per-group scan outputs to one result and drives the insert shift; optional SCAN_RESOLVE_STATS_EN
module scan_result_resolver
  import scan_result_resolver_pkg::*;
#(
  parameter int GROUP_CNT      = SAM_GROUP_CNT,
  parameter int GROUP_ADR_BITS = SAM_GROUP_ADR_BITS,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      scanStart,
  input  logic [2*GROUP_CNT-1:0]    grpRslt,
  input  logic [GROUP_CNT-1:0]      overTgt,
  input  logic [GROUP_CNT-1:0]      stop,
  input  logic [GROUP_CNT-1:0]      rowFull,
  output logic                      rsltValid,
  input  logic                      rsltReady,
  output logic                      rsltHit,
  output logic [GROUP_ADR_BITS-1:0] rsltHitGrp,
  output logic [GROUP_ADR_BITS:0]   rsltInsGrp,
  output logic                      rsltRowFull,
  output logic                      rsltEmpty,
  input  logic                      shiftReq,
  output logic                      shiftErr,
  output logic [GROUP_CNT-1:0]      insertPoint,
  output logic [GROUP_CNT-1:0]      grpMask,
  output logic                      busy
`ifdef SCAN_RESOLVE_STATS_EN
  ,
  output logic [15:0]               statScans,
  output logic [15:0]               statHits,
  output logic [15:0]               statShifts
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [2:0]                state;
  logic [CNT_W-1:0]          settleCnt;
  SCAN_RSLT                  rslt;
  logic [GROUP_CNT-1:0]      validVec, eqVec, ltVec;
  logic                      hitFound, ltFound, stopFound;
  logic [GROUP_ADR_BITS-1:0] hitIdx, ltIdx, stopIdx;
  logic [GROUP_ADR_BITS:0]   insGrpC;
  logic [GROUP_CNT-1:0]      maskC, onehotC;
  logic                      shiftOk;

  // Per-group qualification: only groups over a key and not stopped count
  always_comb begin
    validVec = overTgt & ~stop;
    eqVec    = '0;
    ltVec    = '0;
    for (int g = 0; g < GROUP_CNT; g++) begin
      eqVec[g] = validVec[g] & grpRslt[2*g+CMP_EQ];
      ltVec[g] = validVec[g] & grpRslt[2*g+CMP_LT] & ~grpRslt[2*g+CMP_EQ];
    end
  end

  lowest_set_finder #(.WIDTH(GROUP_CNT), .IDX_BITS(GROUP_ADR_BITS)) uHitFind (
    .vec(eqVec), .found(hitFound), .idx(hitIdx));
  lowest_set_finder #(.WIDTH(GROUP_CNT), .IDX_BITS(GROUP_ADR_BITS)) uLtFind (
    .vec(ltVec), .found(ltFound), .idx(ltIdx));
  lowest_set_finder #(.WIDTH(GROUP_CNT), .IDX_BITS(GROUP_ADR_BITS)) uStopFind (
    .vec(stop), .found(stopFound), .idx(stopIdx));

  // Insertion point: first smaller key, else first stopped group, else append
  always_comb begin
    if (ltFound)        insGrpC = {1'b0, ltIdx};
    else if (stopFound) insGrpC = {1'b0, stopIdx};
    else                insGrpC = (GROUP_ADR_BITS+1)'(GROUP_CNT);
  end

  // Shift pattern derived from the held insertion point
  always_comb begin
    maskC   = '0;
    onehotC = '0;
    for (int g = 0; g < GROUP_CNT; g++) begin
      maskC[g]   = (GROUP_ADR_BITS+1)'(g) < rslt.insGrp;
      onehotC[g] = (GROUP_ADR_BITS+1)'(g) == rslt.insGrp;
    end
  end

  assign shiftOk = ((state == ST_REPORT) || (state == ST_HELD)) && !rslt.rowFull && !rslt.hit;

  // Resolver FSM, result register and one-cycle shift/error outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      settleCnt   <= '0;
      rslt        <= '0;
      grpMask     <= '1;
      insertPoint <= '0;
      shiftErr    <= 1'b0;
    end else begin
      grpMask     <= '1;
      insertPoint <= '0;
      shiftErr    <= 1'b0;
      if (shiftReq) begin
        if (shiftOk) begin
          grpMask     <= maskC;
          insertPoint <= onehotC;
          rslt        <= '0;
        end else begin
          shiftErr    <= 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (scanStart) begin
            state     <= ST_SETTLE;
            settleCnt <= CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (settleCnt == '0) state <= ST_RESOLVE;
          else                 settleCnt <= settleCnt - 1'b1;
        end
        ST_RESOLVE: begin
          rslt.hit     <= hitFound;
          rslt.hitGrp  <= hitIdx;
          rslt.insGrp  <= insGrpC;
          rslt.rowFull <= |rowFull;
          rslt.empty   <= ~|validVec;
          state        <= ST_REPORT;
        end
        ST_REPORT: begin
          if (shiftReq && shiftOk) begin
            state <= ST_IDLE;
          end else if (rsltReady) begin
            if (scanStart) begin
              state     <= ST_SETTLE;
              settleCnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else begin
              state     <= ST_HELD;
            end
          end
        end
        ST_HELD: begin
          if (shiftReq && shiftOk) begin
            state <= ST_IDLE;
          end else if (scanStart) begin
            state     <= ST_SETTLE;
            settleCnt <= CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsltValid   = (state == ST_REPORT);
  assign busy        = (state != ST_IDLE) && (state != ST_HELD);
  assign rsltHit     = rslt.hit;
  assign rsltHitGrp  = rslt.hitGrp;
  assign rsltInsGrp  = rslt.insGrp;
  assign rsltRowFull = rslt.rowFull;
  assign rsltEmpty   = rslt.empty;

`ifdef SCAN_RESOLVE_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      statScans  <= '0;
      statHits   <= '0;
      statShifts <= '0;
    end else begin
      if (state == ST_RESOLVE && statScans != 16'hFFFF) statScans <= statScans + 16'd1;
      if (state == ST_RESOLVE && hitFound && statHits != 16'hFFFF) statHits <= statHits + 16'd1;
      if (shiftReq && shiftOk && statShifts != 16'hFFFF) statShifts <= statShifts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scan_result_resolver.sv
// tb/tb_scan_result_resolver.sv - directed self-checking bench for scan_result_resolver
module tb_scan_result_resolver;

  logic        clk = 1'b0;
  logic        resetN;
  logic        scanStart;
  logic [63:0] grpRslt;
  logic [31:0] overTgt, stop, rowFull;
  logic        rsltValid, rsltReady, rsltHit, rsltRowFull, rsltEmpty;
  logic [4:0]  rsltHitGrp;
  logic [5:0]  rsltInsGrp;
  logic        shiftReq, shiftErr, busy;
  logic [31:0] insertPoint, grpMask;

  int checks = 0;
  int errors = 0;

  scan_result_resolver dut (
    .clk(clk), .resetN(resetN), .scanStart(scanStart), .grpRslt(grpRslt),
    .overTgt(overTgt), .stop(stop), .rowFull(rowFull), .rsltValid(rsltValid),
    .rsltReady(rsltReady), .rsltHit(rsltHit), .rsltHitGrp(rsltHitGrp),
    .rsltInsGrp(rsltInsGrp), .rsltRowFull(rsltRowFull), .rsltEmpty(rsltEmpty),
    .shiftReq(shiftReq), .shiftErr(shiftErr), .insertPoint(insertPoint),
    .grpMask(grpMask), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setGroups(input logic [31:0] ov, input logic [31:0] st,
                           input logic [31:0] eq, input logic [31:0] lt,
                           input logic [31:0] rf);
    overTgt = ov;
    stop    = st;
    rowFull = rf;
    for (int g = 0; g < 32; g++) begin
      grpRslt[2*g+1] = eq[g];
      grpRslt[2*g]   = lt[g];
    end
  endtask

  task automatic doScan(output int lat);
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    lat = 1;
    while (rsltValid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    rsltReady = 1'b1;
    tick();
    rsltReady = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick();
    tick();
    checks++; if (rsltValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsltValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (grpMask !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_mask: got %h expected ffffffff", grpMask); end
    checks++; if (insertPoint !== 32'h0 || shiftErr !== 1'b0) begin errors++; $display("FAIL reset_shift: got ip=%h err=%b expected 0/0", insertPoint, shiftErr); end
    checks++; if ({rsltHit, rsltHitGrp, rsltInsGrp, rsltRowFull, rsltEmpty} !== 14'h0) begin errors++; $display("FAIL reset_rslt: got %h expected 0", {rsltHit, rsltHitGrp, rsltInsGrp, rsltRowFull, rsltEmpty}); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_hit();
    int lat;
    // groups 0-9 valid; eq at 4 and 7, eq at invalid 12, lt at 2
    setGroups(32'h000003FF, 32'h00000400, 32'h00001090, 32'h00000004, 32'h0);
    doScan(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL hit_latency: got %0d expected 4", lat); end
    checks++; if (rsltHit !== 1'b1 || rsltHitGrp !== 5'd4) begin errors++; $display("FAIL hit_grp: got hit=%b grp=%0d expected 1/4", rsltHit, rsltHitGrp); end
    checks++; if (rsltInsGrp !== 6'd2 || rsltEmpty !== 1'b0 || rsltRowFull !== 1'b0) begin errors++; $display("FAIL hit_ins: got ins=%0d e=%b rf=%b expected 2/0/0", rsltInsGrp, rsltEmpty, rsltRowFull); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hit_busy_report: got %b expected 1", busy); end
    handshake();
    checks++; if (rsltValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hit_held: got v=%b busy=%b expected 0/0", rsltValid, busy); end
    shiftReq = 1'b1;
    tick();
    shiftReq = 1'b0;
    checks++; if (shiftErr !== 1'b1 || grpMask !== 32'hFFFFFFFF) begin errors++; $display("FAIL hit_shift_refused: got err=%b mask=%h expected 1/ffffffff", shiftErr, grpMask); end
  endtask

  task automatic test_lt_shift();
    int lat;
    setGroups(32'h000003FF, 32'h0, 32'h0, 32'h00001140, 32'h0);
    doScan(lat);
    checks++; if (lat != 4 || rsltHit !== 1'b0 || rsltInsGrp !== 6'd6) begin errors++; $display("FAIL lt_ins: got lat=%0d hit=%b ins=%0d expected 4/0/6", lat, rsltHit, rsltInsGrp); end
    handshake();
    shiftReq = 1'b1;
    tick();
    shiftReq = 1'b0;
    checks++; if (grpMask !== 32'h0000003F || insertPoint !== 32'h00000040 || shiftErr !== 1'b0) begin errors++; $display("FAIL lt_shift: got mask=%h ip=%h err=%b expected 0000003f/00000040/0", grpMask, insertPoint, shiftErr); end
    tick();
    checks++; if (grpMask !== 32'hFFFFFFFF || insertPoint !== 32'h0 || rsltValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lt_shift_one_cycle: got mask=%h ip=%h v=%b busy=%b expected ffffffff/0/0/0", grpMask, insertPoint, rsltValid, busy); end
    shiftReq = 1'b1;
    tick();
    shiftReq = 1'b0;
    checks++; if (shiftErr !== 1'b1 || grpMask !== 32'hFFFFFFFF) begin errors++; $display("FAIL idle_shift_refused: got err=%b mask=%h expected 1/ffffffff", shiftErr, grpMask); end
    tick();
    checks++; if (shiftErr !== 1'b0) begin errors++; $display("FAIL shifterr_pulse: got %b expected 0", shiftErr); end
  endtask

  task automatic test_stop_ins();
    int lat;
    setGroups(32'h000003FF, 32'h00100400, 32'h0, 32'h0, 32'h0);
    doScan(lat);
    checks++; if (rsltInsGrp !== 6'd10) begin errors++; $display("FAIL stop_ins: got %0d expected 10", rsltInsGrp); end
    // shift together with the handshake: shift wins
    rsltReady = 1'b1;
    shiftReq  = 1'b1;
    tick();
    rsltReady = 1'b0;
    shiftReq  = 1'b0;
    checks++; if (grpMask !== 32'h000003FF || insertPoint !== 32'h00000400 || rsltValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_shift_hs: got mask=%h ip=%h v=%b busy=%b expected 000003ff/00000400/0/0", grpMask, insertPoint, rsltValid, busy); end
    setGroups(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0);
    doScan(lat);
    checks++; if (rsltInsGrp !== 6'd32 || rsltEmpty !== 1'b0) begin errors++; $display("FAIL append_ins: got ins=%0d e=%b expected 32/0", rsltInsGrp, rsltEmpty); end
    shiftReq = 1'b1;
    tick();
    shiftReq = 1'b0;
    checks++; if (insertPoint !== 32'h0 || grpMask !== 32'hFFFFFFFF || shiftErr !== 1'b0) begin errors++; $display("FAIL append_shift: got ip=%h mask=%h err=%b expected 0/ffffffff/0", insertPoint, grpMask, shiftErr); end
    setGroups(32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0);
    doScan(lat);
    checks++; if (rsltEmpty !== 1'b1 || rsltHit !== 1'b0 || rsltInsGrp !== 6'd32) begin errors++; $display("FAIL empty_row: got e=%b hit=%b ins=%0d expected 1/0/32", rsltEmpty, rsltHit, rsltInsGrp); end
    handshake();
  endtask

  task automatic test_rowfull();
    int lat;
    setGroups(32'h000003FF, 32'h0, 32'h0, 32'h00000008, 32'h80000000);
    doScan(lat);
    checks++; if (rsltRowFull !== 1'b1 || rsltInsGrp !== 6'd3) begin errors++; $display("FAIL rowfull_flag: got rf=%b ins=%0d expected 1/3", rsltRowFull, rsltInsGrp); end
    handshake();
    shiftReq = 1'b1;
    tick();
    shiftReq = 1'b0;
    checks++; if (shiftErr !== 1'b1 || grpMask !== 32'hFFFFFFFF || insertPoint !== 32'h0) begin errors++; $display("FAIL rowfull_shift: got err=%b mask=%h ip=%h expected 1/ffffffff/0", shiftErr, grpMask, insertPoint); end
    tick();
    checks++; if (shiftErr !== 1'b0 || rsltRowFull !== 1'b1) begin errors++; $display("FAIL rowfull_retained: got err=%b rf=%b expected 0/1", shiftErr, rsltRowFull); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int drops;
    setGroups(32'h000003FF, 32'h0, 32'h00000100, 32'h0, 32'h0);
    scanStart = 1'b1;
    tick();
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    lat = 2;
    while (rsltValid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4 || rsltHitGrp !== 5'd8) begin errors++; $display("FAIL bp_latency: got lat=%0d grp=%0d expected 4/8", lat, rsltHitGrp); end
    setGroups(32'h000003FF, 32'h0, 32'h00000002, 32'h0, 32'h0);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsltValid !== 1'b1 || rsltHitGrp !== 5'd8 || rsltHit !== 1'b1) drops++;
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", drops); end
    handshake();
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsltValid !== 1'b0) drops++;
      tick();
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL bp_single_result: got %0d extra valid cycles expected 0", drops); end
    // handshake coinciding with a new scan
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (rsltValid !== 1'b1 || rsltHitGrp !== 5'd1) begin errors++; $display("FAIL b2b_first: got v=%b grp=%0d expected 1/1", rsltValid, rsltHitGrp); end
    setGroups(32'h000003FF, 32'h0, 32'h00000020, 32'h0, 32'h0);
    rsltReady = 1'b1;
    scanStart = 1'b1;
    tick();
    rsltReady = 1'b0;
    scanStart = 1'b0;
    checks++; if (rsltValid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_settle: got v=%b busy=%b expected 0/1", rsltValid, busy); end
    lat = 1;
    while (rsltValid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4 || rsltHitGrp !== 5'd5) begin errors++; $display("FAIL b2b_second: got lat=%0d grp=%0d expected 4/5", lat, rsltHitGrp); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    setGroups(32'h000003FF, 32'h0, 32'h00000200, 32'h0, 32'h0);
    doScan(lat);
    handshake();
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || rsltHit !== 1'b1) begin errors++; $display("FAIL mid_pre: got busy=%b hit=%b expected 1/1", busy, rsltHit); end
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsltHit !== 1'b0 || rsltHitGrp !== 5'd0 || grpMask !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_async_clear: got busy=%b hit=%b grp=%0d mask=%h expected 0/0/0/ffffffff", busy, rsltHit, rsltHitGrp, grpMask); end
    tick();
    resetN = 1'b1;
    tick();
    setGroups(32'h000003FF, 32'h0, 32'h0, 32'h00000008, 32'h0);
    doScan(lat);
    checks++; if (lat != 4 || rsltHit !== 1'b0 || rsltInsGrp !== 6'd3) begin errors++; $display("FAIL mid_fresh: got lat=%0d hit=%b ins=%0d expected 4/0/3", lat, rsltHit, rsltInsGrp); end
    handshake();
  endtask

  initial begin
    resetN    = 1'b0;
    scanStart = 1'b0;
    rsltReady = 1'b0;
    shiftReq  = 1'b0;
    grpRslt   = '0;
    overTgt   = '0;
    stop      = '0;
    rowFull   = '0;
    test_reset();
    test_hit();
    test_lt_shift();
    test_stop_ins();
    test_rowfull();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
